// File: rtl/barrel_pkg.sv
// barrel_pkg: shift-mode encodings shared by the barrel shifter pipeline.
package barrel_pkg;
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_LSL = 2'b00;
    localparam mode_t MODE_LSR = 2'b01;
    localparam mode_t MODE_ASR = 2'b10;
    localparam mode_t MODE_ROR = 2'b11;
endpackage

// File: rtl/barrel_stage.sv
// barrel_stage: one conditional shift-by-SHIFT stage with its valid/ready pipeline register.
// Carry tracking is compiled in only when BARREL_CARRY_EN is defined.
module barrel_stage
    import barrel_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHIFT   = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
`ifdef BARREL_CARRY_EN
    input  logic               in_carry,
    output logic               out_carry,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [1:0]         out_mode
);
    localparam int K = $clog2(SHIFT);
    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    logic [SHAMT_W-1:0] r_shamt;
    logic [1:0]         r_mode;
    logic [WIDTH-1:0]   w_data;
    assign w_data = !in_shamt[K]         ? in_data :
                    in_mode == MODE_LSL  ? {in_data[WIDTH-SHIFT-1:0], {SHIFT{1'b0}}} :
                    in_mode == MODE_LSR  ? {{SHIFT{1'b0}}, in_data[WIDTH-1:SHIFT]} :
                    in_mode == MODE_ASR  ? {{SHIFT{in_data[WIDTH-1]}}, in_data[WIDTH-1:SHIFT]} :
                                           {in_data[SHIFT-1:0], in_data[WIDTH-1:SHIFT]};
    assign in_ready  = !r_valid || out_ready;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_shamt = r_shamt;
    assign out_mode  = r_mode;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_shamt <= '0;
            r_mode  <= '0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data  <= w_data;
                r_shamt <= in_shamt;
                r_mode  <= in_mode;
            end
        end
    end
`ifdef BARREL_CARRY_EN
    logic r_carry;
    // ROR carry equals the rotated result MSB, which is the same source bit as LSR
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_carry <= 1'b0;
        else if (in_ready && in_valid)
            r_carry <= !in_shamt[K]        ? in_carry :
                       in_mode == MODE_LSL ? in_data[WIDTH-SHIFT] : in_data[SHIFT-1];
    end
    assign out_carry = r_carry;
`endif
endmodule

// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe: pipelined barrel shifter/rotator, one log2 stage per register, valid/ready on both sides.
// Define BARREL_CARRY_EN to add the out_carry port and carry pipeline.
module barrel_shift_pipe
    import barrel_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    output logic               out_valid,
    input  logic               out_ready,
`ifdef BARREL_CARRY_EN
    output logic               out_carry,
`endif
    output logic [WIDTH-1:0]   out_data
);
    logic [SHAMT_W:0]   w_valid;
    logic [SHAMT_W:0]   w_ready;
    logic [WIDTH-1:0]   w_data  [SHAMT_W+1];
    logic [SHAMT_W-1:0] w_shamt [SHAMT_W+1];
    logic [1:0]         w_mode  [SHAMT_W+1];
    logic               r_init;
    // hold off intake until the first clock after reset release
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_init <= 1'b0;
        else
            r_init <= 1'b1;
    end
    assign in_ready         = r_init && w_ready[0];
    assign w_valid[0]       = r_init && in_valid;
    assign w_data[0]        = in_data;
    assign w_shamt[0]       = in_shamt;
    assign w_mode[0]        = in_mode;
    assign w_ready[SHAMT_W] = out_ready;
    assign out_valid        = w_valid[SHAMT_W];
    assign out_data         = w_data[SHAMT_W];
`ifdef BARREL_CARRY_EN
    logic [SHAMT_W:0] w_carry;
    assign w_carry[0] = 1'b0;
    assign out_carry  = w_carry[SHAMT_W];
`endif
    for (genvar g = 0; g < SHAMT_W; g++) begin : g_stage
        barrel_stage #(
            .WIDTH   (WIDTH),
            .SHIFT   (1 << g),
            .SHAMT_W (SHAMT_W)
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (w_valid[g]),
            .in_ready  (w_ready[g]),
            .in_data   (w_data[g]),
            .in_shamt  (w_shamt[g]),
            .in_mode   (w_mode[g]),
`ifdef BARREL_CARRY_EN
            .in_carry  (w_carry[g]),
            .out_carry (w_carry[g+1]),
`endif
            .out_valid (w_valid[g+1]),
            .out_ready (w_ready[g+1]),
            .out_data  (w_data[g+1]),
            .out_shamt (w_shamt[g+1]),
            .out_mode  (w_mode[g+1])
        );
    end
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// tb_barrel_shift_pipe: directed vectors, random traffic against a scoreboard model, stall and reset sequences.
module tb_barrel_shift_pipe;
    import barrel_pkg::*;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_shamt = '0;
    logic [1:0] in_mode = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
`ifdef BARREL_CARRY_EN
    logic       out_carry;
`endif
    barrel_shift_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef BARREL_CARRY_EN
        .out_carry (out_carry),
`endif
        .out_data  (out_data)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [7:0] d;
        logic [2:0] s;
        logic [1:0] m;
        logic [7:0] ed;
        logic       ec;
    } vec_t;
    vec_t       vecs[8];
    int         n_checks = 0;
    int         n_fail = 0;
    int         n_cons = 0;
    logic       acc;
    logic       got;
    logic [7:0] last_data;
    logic       last_carry;
    logic [8:0] q[$];
    function automatic logic [8:0] model(input logic [7:0] d, input int n, input logic [1:0] m);
        int x = int'(d);
        int r;
        int c;
        if (m == MODE_LSL) begin
            r = (x << n) & 255;
            c = n == 0 ? 0 : (x >> (8 - n)) & 1;
        end else if (m == MODE_LSR) begin
            r = x >> n;
            c = n == 0 ? 0 : (x >> (n - 1)) & 1;
        end else if (m == MODE_ASR) begin
            r = (x >> n) | (x >= 128 ? (255 << (8 - n)) & 255 : 0);
            c = n == 0 ? 0 : (x >> (n - 1)) & 1;
        end else begin
            r = ((x >> n) | (x << (8 - n))) & 255;
            c = n == 0 ? 0 : (r >> 7) & 1;
        end
        return {c[0], r[7:0]};
    endfunction
    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask
    // one clock: drive, sample handshakes just before the edge, score, advance
    task automatic cyc(input logic v, input logic [7:0] d, input logic [2:0] s, input logic [1:0] m, input logic r);
        logic [8:0] e;
        in_valid = v;
        in_data = d;
        in_shamt = s;
        in_mode = m;
        out_ready = r;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_cons++;
            got = 1'b1;
            last_data = out_data;
`ifdef BARREL_CARRY_EN
            last_carry = out_carry;
`endif
            if (q.size() == 0) begin
                chk("spurious_result", 1, 0);
            end else begin
                e = q.pop_front();
                chk("sb_data", int'(out_data), int'(e[7:0]));
`ifdef BARREL_CARRY_EN
                chk("sb_carry", int'(out_carry), int'(e[8]));
`endif
            end
        end
        if (acc) q.push_back(model(d, int'(s), m));
        @(posedge clk);
        #1;
    endtask
    task automatic single(input logic [7:0] d, input logic [2:0] s, input logic [1:0] m, output int lat);
        lat = 0;
        got = 1'b0;
        cyc(1'b1, d, s, m, 1'b1);
        while (!got && lat < 10) begin
            lat++;
            cyc(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        end
    endtask
    task automatic drain();
        for (int c = 0; c < 20 && q.size() > 0; c++) cyc(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        chk("drain_empty", q.size(), 0);
    endtask
    initial begin
        int lat;
        int na;
        int nc0;
        int nxt;
        logic [7:0] hold;
        logic [7:0] bd[5];
        logic [2:0] bs[5];
        logic [1:0] bm[5];
        vecs[0] = '{8'hAA, 3'd1, MODE_LSL, 8'h54, 1'b1};
        vecs[1] = '{8'hAA, 3'd2, MODE_LSR, 8'h2A, 1'b1};
        vecs[2] = '{8'h96, 3'd3, MODE_ASR, 8'hF2, 1'b1};
        vecs[3] = '{8'hAA, 3'd5, MODE_ROR, 8'h55, 1'b0};
        vecs[4] = '{8'h3C, 3'd0, MODE_LSL, 8'h3C, 1'b0};
        vecs[5] = '{8'h3C, 3'd0, MODE_LSR, 8'h3C, 1'b0};
        vecs[6] = '{8'h3C, 3'd0, MODE_ASR, 8'h3C, 1'b0};
        vecs[7] = '{8'h3C, 3'd0, MODE_ROR, 8'h3C, 1'b0};
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("in_ready_after_rst", int'(in_ready), 1);
        foreach (vecs[i]) begin
            single(vecs[i].d, vecs[i].s, vecs[i].m, lat);
            chk("vec_latency", lat, 3);
            chk("vec_data", int'(last_data), int'(vecs[i].ed));
`ifdef BARREL_CARRY_EN
            chk("vec_carry", int'(last_carry), int'(vecs[i].ec));
`endif
        end
        nc0 = n_cons;
        na = 0;
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 8'($urandom), 3'($urandom), 2'($urandom), 1'b1);
            na += int'(acc);
        end
        chk("thru_accepts", na, 16);
        chk("thru_results", n_cons - nc0, 13);
        drain();
        for (int i = 0; i < 5; i++) begin
            bd[i] = 8'($urandom);
            bs[i] = 3'($urandom_range(1, 7));
            bm[i] = 2'($urandom);
        end
        nc0 = n_cons;
        nxt = 0;
        for (int c = 0; c < 4; c++) begin
            cyc(1'b1, bd[nxt], bs[nxt], bm[nxt], 1'b0);
            if (acc) nxt++;
        end
        chk("bp_accepted", nxt, 3);
        chk("bp_in_ready_low", int'(in_ready), 0);
        chk("bp_out_valid", int'(out_valid), 1);
        hold = out_data;
        chk("bp_head_data", int'(hold), int'(model(bd[0], int'(bs[0]), bm[0]) & 9'h0FF));
        for (int c = 0; c < 3; c++) begin
            cyc(1'b1, bd[nxt], bs[nxt], bm[nxt], 1'b0);
            chk("bp_stable", int'(out_data), int'(hold));
            chk("bp_stall_ready", int'(in_ready), 0);
        end
        for (int c = 0; c < 30 && (nxt < 5 || q.size() > 0); c++) begin
            if (nxt < 5) begin
                cyc(1'b1, bd[nxt], bs[nxt], bm[nxt], 1'b1);
                if (acc) nxt++;
            end else begin
                cyc(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
            end
        end
        chk("bp_results", n_cons - nc0, 5);
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) != 0), 8'($urandom), 3'($urandom), 2'($urandom),
                1'($urandom_range(0, 3) != 0));
        drain();
        cyc(1'b1, 8'hAA, 3'd1, MODE_LSL, 1'b0);
        cyc(1'b1, 8'h96, 3'd3, MODE_ASR, 1'b0);
        cyc(1'b0, 8'h00, 3'd0, 2'd0, 1'b0);
        chk("mid_valid_before_rst", int'(out_valid), 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_data", int'(out_data), 0);
        q.delete();
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;
        nc0 = n_cons;
        for (int c = 0; c < 6; c++) cyc(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        chk("mid_no_stale", n_cons - nc0, 0);
        single(8'h96, 3'd3, MODE_ASR, lat);
        chk("mid_next_latency", lat, 3);
        chk("mid_next_data", int'(last_data), 8'hF2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
